// File: rtl/main_fsm_pkg.sv
`default_nettype none
// ============================================================================
// main_fsm_pkg : shared state, mux-select and opcode encodings for the core
// Rev 1.0
// ============================================================================
package main_fsm_pkg;

   localparam logic [3:0] ST_FETCH    = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_MEMADR   = 4'd2;
   localparam logic [3:0] ST_MEMRD    = 4'd3;
   localparam logic [3:0] ST_MEMWB    = 4'd4;
   localparam logic [3:0] ST_MEMWR    = 4'd5;
   localparam logic [3:0] ST_EXECUTER = 4'd6;
   localparam logic [3:0] ST_EXECUTEI = 4'd7;
   localparam logic [3:0] ST_ALUWB    = 4'd8;
   localparam logic [3:0] ST_BRANCH   = 4'd9;
   localparam logic [3:0] ST_UNKNOWN  = 4'd10;

   typedef enum logic [3:0] {
      S_FETCH    = ST_FETCH,
      S_DECODE   = ST_DECODE,
      S_MEMADR   = ST_MEMADR,
      S_MEMRD    = ST_MEMRD,
      S_MEMWB    = ST_MEMWB,
      S_MEMWR    = ST_MEMWR,
      S_EXECUTER = ST_EXECUTER,
      S_EXECUTEI = ST_EXECUTEI,
      S_ALUWB    = ST_ALUWB,
      S_BRANCH   = ST_BRANCH,
      S_UNKNOWN  = ST_UNKNOWN
   } state_t;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_4     = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] OP_DP      = 2'b00;
   localparam logic [1:0] OP_MEM     = 2'b01;
   localparam logic [1:0] OP_BR      = 2'b10;

endpackage : main_fsm_pkg
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
// main_fsm : Moore sequencer stepping each instruction through its cycles
// Rev 1.0
// ============================================================================
module main_fsm
   import main_fsm_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   output logic               IRWrite,
   output logic               AdrSrc,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic               NextPC,
   output logic               RegW,
   output logic               MemW,
   output logic               Branch,
   output logic               ALUOp,
   output logic [STATE_W-1:0] state
);

   state_t r_state;
   state_t w_next;

   // Only the immediate and load flags steer the sequence.
   logic w_unused_funct;
   assign w_unused_funct = &{1'b0, Funct[4:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_DP:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_MEM:  w_next = S_MEMADR;
               OP_BR:   w_next = S_BRANCH;
               default: w_next = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   w_next = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    w_next = S_MEMWB;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      case (r_state)
         S_FETCH: begin
            NextPC    = 1'b1;
            IRWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_4;
            ResultSrc = RES_ALU;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_4;
            ResultSrc = RES_ALU;
         end
         S_MEMADR:   ALUSrcB = SRCB_IMM;
         S_MEMRD:    AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegW      = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         S_EXECUTER: ALUOp = 1'b1;
         S_EXECUTEI: begin
            ALUSrcB = SRCB_IMM;
            ALUOp   = 1'b1;
         end
         S_ALUWB:    RegW = 1'b1;
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALU;
            Branch    = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = STATE_W'(r_state);

endmodule : main_fsm
`default_nettype wire

// File: tb/tb_main_fsm.sv
`default_nettype none
// ============================================================================
// tb_main_fsm : directed-vector bench for the multicycle main sequencer
// Rev 1.0
// ============================================================================
module tb_main_fsm;
   import main_fsm_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'd0;
   logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
   logic [1:0] ALUSrcB, ResultSrc;
   logic [3:0] state;

   int n_vec = 0;
   int n_err = 0;

   main_fsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .NextPC(NextPC),
      .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {NextPC,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,RegW,MemW,Branch,ALUOp}
   function automatic logic [11:0] exp_vec(input logic [3:0] s);
      case (s)
         4'd0:    return 12'b1_1_0_1_10_10_0_0_0_0;
         4'd1:    return 12'b0_0_0_1_10_10_0_0_0_0;
         4'd2:    return 12'b0_0_0_0_01_00_0_0_0_0;
         4'd3:    return 12'b0_0_1_0_00_00_0_0_0_0;
         4'd4:    return 12'b0_0_0_0_00_01_1_0_0_0;
         4'd5:    return 12'b0_0_1_0_00_00_0_1_0_0;
         4'd6:    return 12'b0_0_0_0_00_00_0_0_0_1;
         4'd7:    return 12'b0_0_0_0_01_00_0_0_0_1;
         4'd8:    return 12'b0_0_0_0_00_00_1_0_0_0;
         4'd9:    return 12'b0_0_0_0_01_10_0_0_1_0;
         default: return 12'b0;
      endcase
   endfunction

   function automatic logic [11:0] obs_vec();
      return {NextPC, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
              RegW, MemW, Branch, ALUOp};
   endfunction

   // seq holds expected states, first in the low nibble. Called at a negedge
   // while in FETCH; returns at the negedge of the following FETCH.
   task automatic run_instr(input string name, input logic [1:0] op,
                            input logic [5:0] funct, input logic [23:0] seq,
                            input int n);
      logic [3:0] es;
      for (int i = 0; i < n; i++) begin
         es = seq[4*i +: 4];
         chk({name, "_state"}, 32'(state), 32'(es));
         chk({name, "_outs"}, 32'(obs_vec()), 32'(exp_vec(es)));
         // Op/Funct must only matter in DECODE and MEMADR
         if (es == 4'd1 || es == 4'd2) begin
            Op = op;  Funct = funct;
         end else begin
            Op = ~op; Funct = ~funct;
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_outs", 32'(obs_vec()), 32'(exp_vec(4'd0)));
      reset = 1'b0;
      chk("post_rst_outs", 32'(obs_vec()), 32'(exp_vec(4'd0)));

      run_instr("add_reg", OP_DP,  6'b001000, {4'd8, 4'd6, 4'd1, 4'd0}, 4);
      run_instr("add_imm", OP_DP,  6'b101000, {4'd8, 4'd7, 4'd1, 4'd0}, 4);
      run_instr("ldr",     OP_MEM, 6'b011001, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5);
      run_instr("str",     OP_MEM, 6'b011000, {4'd5, 4'd2, 4'd1, 4'd0}, 4);
      run_instr("b",       OP_BR,  6'b000000, {4'd9, 4'd1, 4'd0}, 3);
      run_instr("undef",   2'b11,  6'b000000, {4'd10, 4'd1, 4'd0}, 3);
      chk("end_state", 32'(state), 32'd0);

      // STR up to MEMWR, then reset asynchronously mid-cycle
      run_instr("str2",    OP_MEM, 6'b011000, {4'd2, 4'd1, 4'd0}, 3);
      chk("memwr_state", 32'(state), 32'd5);
      chk("memwr_memw", 32'(MemW), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_memw", 32'(MemW), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rel_nextpc", 32'(NextPC), 32'd1);
      chk("rel_irwrite", 32'(IRWrite), 32'd1);
      chk("rel_alusrcb", 32'(ALUSrcB), 32'(SRCB_4));
      @(posedge clk);
      @(negedge clk);
      chk("rel_decode", 32'(state), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_main_fsm
`default_nettype wire

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Moore sequencer for the multicycle ARM core. It sits directly upstream of the instruction decoder and condition logic inside the controller.
- Steps every instruction through fetch, decode, execute, memory and writeback cycles.
- Produces the per-cycle datapath enables and mux selects: NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc.
- Also produces Branch and ALUOp, which the decoder consumes to form PCS and ALUControl.

Parameters:
STATE_W, 4, width of state register and of debug state output

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Op  input  2  instruction class, from IR bits 27:26
Funct  input  6  IR bits 25:20; bit 5 = immediate (I), bit 0 = load (L)
IRWrite  output  1  load instruction register
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result
ALUSrcA  output  1  ALU A select: 0 = register A, 1 = PC
ALUSrcB  output  2  ALU B select: 00 = reg B, 01 = ExtImm, 10 = constant 4
ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
NextPC  output  1  request PC update (PC+4)
RegW  output  1  unconditioned register write request
MemW  output  1  unconditioned memory write request
Branch  output  1  branch cycle, decoder ORs into PCS
ALUOp  output  1  1 = decoder applies Funct-based ALU decode; 0 = ADD
state  output  STATE_W  current state, for debug display

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on reset, forcing state to FETCH (0) immediately.
- Output style: outputs are a pure combinational decode of the state register (Moore). No input-to-output path.
- Reset values: outputs equal the FETCH vector while reset is high and in the first cycle after release. FETCH vector: NextPC=1, IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0, RegW=MemW=Branch=0, state=0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11-15 are unreachable; they decode like UNKNOWN and go to FETCH.
- Transitions (one per clock):
  - FETCH->DECODE.
  - DECODE:
    - Op=00 and Funct[5]=0 -> EXECUTER.
    - Op=00 and Funct[5]=1 -> EXECUTEI.
    - Op=01 -> MEMADR.
    - Op=10 -> BRANCH.
    - Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH.
  - EXECUTER/EXECUTEI->ALUWB->FETCH.
  - BRANCH->FETCH.
  - UNKNOWN->FETCH.
- Op and Funct are sampled only in DECODE and MEMADR; they are ignored in all other states.
- Outputs per state (any field not listed is 0):
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: all zero.
- Latencies in cycles:
  - data processing: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - undefined Op=11: 3
- Per-cycle exclusivity:
  - NextPC and IRWrite are both asserted only in FETCH.
  - At most one of RegW, MemW, Branch is asserted per cycle.
  - RegW/MemW are never asserted in FETCH or DECODE.
- Reset mid-instruction: state returns to FETCH asynchronously and any pending RegW/MemW drops in the same cycle. No partial write may complete after reset assertion.
- Conditional suppression of RegW/MemW/Branch is not done here; it belongs to the condition logic downstream.

Decomposition:
- Shared package (core-wide, used by decoder and bench):
  - state codes as localparams.
  - ALUSrcB codes SRCB_REG/SRCB_IMM/SRCB_4.
  - ResultSrc codes RES_ALUOUT/RES_DATA/RES_ALU.
  - Op codes OP_DP/OP_MEM/OP_BR.
- Sub-modules: none required. The next-state logic and output decode are each one case statement in this module.

Test Plan:
- Reset: assert reset mid-MEMWR (state=5) -> state=0 and MemW=0 within the same cycle. After release: NextPC=1, IRWrite=1, ALUSrcB=10.
- ADD reg (Op=00, Funct=001000): states 0,1,6,8,0. ALUOp=1 only in cycle 3; RegW=1 only in cycle 4; ALUSrcB=00 in EXECUTER.
- ADD imm (Op=00, Funct=101000): states 0,1,7,8,0. ALUSrcB=01 in EXECUTEI.
- LDR (Op=01, Funct=011001): states 0,1,2,3,4,0. AdrSrc=1 in MEMRD; ResultSrc=01 and RegW=1 in MEMWB.
- STR (Op=01, Funct=011000): states 0,1,2,5,0. MemW=1 only in MEMWR; RegW never 1.
- B (Op=10), then Op=11: branch path 0,1,9,0 with Branch=1 and ResultSrc=10 in state 9; undefined path 0,1,10,0 with all outputs 0 in state 10.
